// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeats it
// a programmed number of times, and can insert idle zero cycles between repetitions.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int BC_W = $clog2(PAT_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] sr_reg;
    logic [PAT_W-1:0] pl_reg;
    logic [BC_W-1:0]  bit_reg;
    logic [CNT_W-1:0] rc_reg;
    logic [GAP_W-1:0] gc_reg;
    logic [GAP_W-1:0] gl_reg;
    logic [CNT_W-1:0] rc_next;

    assign rc_next = rc_reg - CNT_W'(1);

    // Outputs are registered alongside the state, so each branch sets the
    // values that will be visible during the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            sr_reg    <= '0;
            pl_reg    <= '0;
            bit_reg   <= '0;
            rc_reg    <= '0;
            gc_reg    <= '0;
            gl_reg    <= '0;
            a         <= 1'b0;
            a_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state_reg <= ST_IDLE;
            a         <= 1'b0;
            a_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    a       <= 1'b0;
                    a_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (reps == '0) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= ST_SEND;
                            sr_reg    <= pattern_in;
                            pl_reg    <= pattern_in;
                            rc_reg    <= reps;
                            gl_reg    <= gap;
                            bit_reg   <= '0;
                            a         <= pattern_in[PAT_W-1];
                            a_valid   <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    sr_reg  <= sr_reg << 1;
                    bit_reg <= bit_reg + BC_W'(1);
                    a       <= sr_reg[PAT_W-2];
                    a_valid <= 1'b1;
                    if (bit_reg == LAST_BIT) begin
                        rc_reg  <= rc_next;
                        bit_reg <= '0;
                        if (rc_next == '0) begin
                            state_reg <= ST_DONE;
                            a         <= 1'b0;
                            a_valid   <= 1'b0;
                            done      <= 1'b1;
                        end else if (gl_reg == '0) begin
                            // Back-to-back repetition: restart straight from the latched pattern.
                            sr_reg <= pl_reg;
                            a      <= pl_reg[PAT_W-1];
                        end else begin
                            state_reg <= ST_GAP;
                            gc_reg    <= gl_reg;
                            a         <= 1'b0;
                            a_valid   <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    gc_reg <= gc_reg - GAP_W'(1);
                    if (gc_reg == GAP_W'(1)) begin
                        state_reg <= ST_SEND;
                        sr_reg    <= pl_reg;
                        bit_reg   <= '0;
                        a         <= pl_reg[PAT_W-1];
                        a_valid   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    a         <= 1'b0;
                    a_valid   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: literal vector table, hand-written corner
// sequences, and randomized jobs against a bit-stream reference model.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PAT_W-1:0] pattern_in = '0;
    logic [CNT_W-1:0] reps = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             a, a_valid, busy, done;

    int checks = 0;
    int failures = 0;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
        .reps(reps), .gap(gap), .abort(abort),
        .a(a), .a_valid(a_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the sampling point of cycle N+1 (one unit after accepting edge N).
    task automatic launch(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r,
                          input logic [GAP_W-1:0] g);
        @(negedge clk);
        start = 1'b1;
        pattern_in = p;
        reps = r;
        gap = g;
        @(posedge clk);
        #1;
        start = 1'b0;
        pattern_in = PAT_W'($urandom);
        reps = CNT_W'($urandom);
        gap = GAP_W'($urandom);
    endtask

    typedef struct {
        logic [PAT_W-1:0] pat;
        logic [CNT_W-1:0] reps;
        logic [GAP_W-1:0] gap;
        int               done_k;   // cycle after start in which done is high
        logic [15:0]      a_exp;    // bit 15 = cycle N+1
        logic [15:0]      v_exp;
    } vec_t;

    typedef struct {
        logic a;
        logic v;
    } bit_t;

    vec_t tbl[5];

    initial begin
        logic [2:0]  hist;
        logic [7:0]  stream;
        int          pulse_mask;
        bit_t        q[$];
        logic [PAT_W-1:0] p;
        logic [CNT_W-1:0] r;
        logic [GAP_W-1:0] g;
        int dk, inj;

        tbl[0] = '{4'b1101, 4'd1, 4'd0, 5,  16'b1101_0000_0000_0000, 16'b1111_0000_0000_0000};
        tbl[1] = '{4'b1101, 4'd3, 4'd2, 17, 16'b1101_0011_0100_1101, 16'b1111_0011_1100_1111};
        tbl[2] = '{4'b1101, 4'd2, 4'd0, 9,  16'b1101_1101_0000_0000, 16'b1111_1111_0000_0000};
        tbl[3] = '{4'b1101, 4'd0, 4'd5, 1,  16'b0000_0000_0000_0000, 16'b0000_0000_0000_0000};
        tbl[4] = '{4'b1010, 4'd2, 4'd1, 10, 16'b1010_0101_0000_0000, 16'b1111_0111_1000_0000};

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk1("rst_a", a, 1'b0);
        chk1("rst_a_valid", a_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();
        chk1("post_rst_busy", busy, 1'b0);

        // Literal vector table
        for (int i = 0; i < 5; i++) begin
            $display("table job %0d pat=%b reps=%0d gap=%0d", i, tbl[i].pat, tbl[i].reps, tbl[i].gap);
            launch(tbl[i].pat, tbl[i].reps, tbl[i].gap);
            for (int k = 1; k <= tbl[i].done_k + 1; k++) begin
                if (k < tbl[i].done_k) begin
                    chk1($sformatf("tbl%0d_a_k%0d", i, k), a, tbl[i].a_exp[16-k]);
                    chk1($sformatf("tbl%0d_v_k%0d", i, k), a_valid, tbl[i].v_exp[16-k]);
                    chk1($sformatf("tbl%0d_busy_k%0d", i, k), busy, 1'b1);
                    chk1($sformatf("tbl%0d_done_k%0d", i, k), done, 1'b0);
                end else if (k == tbl[i].done_k) begin
                    chk1($sformatf("tbl%0d_done_k%0d", i, k), done, 1'b1);
                    chk1($sformatf("tbl%0d_busy_k%0d", i, k), busy, 1'b1);
                    chk1($sformatf("tbl%0d_v_k%0d", i, k), a_valid, 1'b0);
                end else begin
                    chk1($sformatf("tbl%0d_idle_busy", i), busy, 1'b0);
                    chk1($sformatf("tbl%0d_idle_done", i), done, 1'b0);
                end
                if (k <= tbl[i].done_k) step();
            end
        end

        // Loopback into a 1101 overlapping Mealy detector
        $display("loopback job pat=1101 reps=2 gap=0");
        hist = 3'b000;
        stream = '0;
        pulse_mask = 0;
        launch(4'b1101, 4'd2, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            if ({hist, a} == 4'b1101) pulse_mask |= (1 << k);
            if (k <= 8) stream = {stream[6:0], a};
            hist = {hist[1:0], a};
            if (k < 10) step();
        end
        chk("loop_stream", int'(stream), int'(8'b1101_1101));
        chk("loop_pulses", pulse_mask, (1 << 4) | (1 << 8));

        // Abort during the third bit, then an immediate new job
        $display("abort job pat=1101 reps=1 gap=0");
        launch(4'b1101, 4'd1, 4'd0);
        step();
        step();
        chk1("abort_bit3_a", a, 1'b0);
        chk1("abort_bit3_v", a_valid, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk1("abort_a", a, 1'b0);
        chk1("abort_v", a_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        start = 1'b1;
        pattern_in = 4'b1011;
        reps = 4'd1;
        gap = 4'd0;
        step();
        start = 1'b0;
        chk1("abort_restart_v", a_valid, 1'b1);
        chk1("abort_restart_a", a, 1'b1);
        chk1("abort_restart_done", done, 1'b0);
        repeat (4) step();
        chk1("abort_restart_done_k5", done, 1'b1);
        step();
        chk1("abort_restart_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a gap
        $display("reset job pat=1111 reps=3 gap=4");
        launch(4'b1111, 4'd3, 4'd4);
        repeat (5) step();
        chk1("rgap_v", a_valid, 1'b0);
        chk1("rgap_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rgap_async_busy", busy, 1'b0);
        chk1("rgap_async_a", a, 1'b0);
        chk1("rgap_async_v", a_valid, 1'b0);
        chk1("rgap_async_done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1($sformatf("rgap_idle_busy%0d", k), busy, 1'b0);
            chk1($sformatf("rgap_idle_v%0d", k), a_valid, 1'b0);
            chk1($sformatf("rgap_idle_done%0d", k), done, 1'b0);
        end
        launch(4'b1001, 4'd1, 4'd0);
        chk1("rgap_new_v", a_valid, 1'b1);
        chk1("rgap_new_a", a, 1'b1);
        repeat (4) step();
        chk1("rgap_new_done", done, 1'b1);
        step();

        // Randomized jobs with a stray start pulse while busy
        for (int j = 0; j < 25; j++) begin
            p = PAT_W'($urandom);
            r = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom_range(0, 15)) : CNT_W'($urandom_range(0, 4));
            g = ($urandom_range(0, 3) == 0) ? GAP_W'($urandom_range(0, 15)) : GAP_W'($urandom_range(0, 3));
            if (j == 0) begin
                r = '1;
                g = '1;
            end
            q.delete();
            for (int rr = 0; rr < int'(r); rr++) begin
                for (int b = PAT_W - 1; b >= 0; b--) q.push_back('{p[b], 1'b1});
                if (rr < int'(r) - 1)
                    for (int gg = 0; gg < int'(g); gg++) q.push_back('{1'b0, 1'b0});
            end
            dk = q.size() + 1;
            inj = $urandom_range(1, dk);
            $display("random job %0d pat=%b reps=%0d gap=%0d cycles=%0d", j, p, r, g, dk);
            launch(p, r, g);
            for (int k = 1; k <= dk + 1; k++) begin
                if (k < dk) begin
                    chk1($sformatf("rnd%0d_a_k%0d", j, k), a, q[k-1].a);
                    chk1($sformatf("rnd%0d_v_k%0d", j, k), a_valid, q[k-1].v);
                    chk1($sformatf("rnd%0d_busy_k%0d", j, k), busy, 1'b1);
                    chk1($sformatf("rnd%0d_done_k%0d", j, k), done, 1'b0);
                end else if (k == dk) begin
                    chk1($sformatf("rnd%0d_done", j), done, 1'b1);
                    chk1($sformatf("rnd%0d_done_busy", j), busy, 1'b1);
                    chk1($sformatf("rnd%0d_done_v", j), a_valid, 1'b0);
                end else begin
                    chk1($sformatf("rnd%0d_idle_busy", j), busy, 1'b0);
                    chk1($sformatf("rnd%0d_idle_done", j), done, 1'b0);
                end
                if (k <= dk) begin
                    start = (k == inj);
                    if (start) pattern_in = ~p;
                    step();
                    start = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
